// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: a free-running period counter with
// double-buffered per-channel start/width/repeat windows.

module ptg_chan #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          first,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] start,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] rep,
  output logic          pulse_q
);
  localparam int EW = CW + 9;

  logic [EW-1:0] ns_q, ns_d, end_q, end_d;
  logic [8:0]    left_q, left_d;
  logic          pulse_d;

  // Windows start in ascending order, so the output is high while the count
  // is below the furthest end of any window already opened this period.
  always_comb begin
    ns_d    = first ? EW'(start) : ns_q;
    left_d  = first ? ({1'b0, rep[7:0]} + 9'd1) : left_q;
    end_d   = first ? '0 : end_q;
    pulse_d = 1'b0;
    if (go) begin
      if (left_d != 9'd0 && ns_d == EW'(cnt)) begin
        if (ns_d + EW'(width) > end_d) end_d = ns_d + EW'(width);
        ns_d   = ns_d + EW'(rep[CW-1:8]);
        left_d = (rep[CW-1:8] == '0) ? 9'd0 : left_d - 9'd1;
      end
      pulse_d = end_d > EW'(cnt);
    end else begin
      ns_d   = '0;
      left_d = '0;
      end_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ns_q    <= '0;
      left_q  <= '0;
      end_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      ns_q    <= ns_d;
      left_q  <= left_d;
      end_q   <= end_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

module pulse_train_gen #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           cfg_we,
  input  logic [4:0]     cfg_addr,
  input  logic [CW-1:0]  cfg_data,
  output logic           sync_out,
  output logic [NCH-1:0] pulse_out,
  output logic [15:0]    per_count,
  output logic           active
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sync_q, sync_d, active_q, active_d;
  logic [15:0]             pc_q, pc_d;
  logic [NCH-1:0]          pulse_q;
  logic [CW-1:0]           per_sh_q, per_sh_d, per_a_q, per_a_d;
  logic [NCH-1:0][CW-1:0]  st_sh_q, st_sh_d, st_a_q, st_a_d;
  logic [NCH-1:0][CW-1:0]  wd_sh_q, wd_sh_d, wd_a_q, wd_a_d;
  logic [NCH-1:0][CW-1:0]  rp_sh_q, rp_sh_d, rp_a_q, rp_a_d;
  logic                    load, go;

  always_comb begin
    per_sh_d = per_sh_q;
    st_sh_d  = st_sh_q;
    wd_sh_d  = wd_sh_q;
    rp_sh_d  = rp_sh_q;
    if (cfg_we) begin
      if (cfg_addr == 5'd0) per_sh_d = cfg_data;
      for (int k = 0; k < NCH; k++) begin
        if (cfg_addr == 5'(3*k + 1)) st_sh_d[k] = cfg_data;
        if (cfg_addr == 5'(3*k + 2)) wd_sh_d[k] = cfg_data;
        if (cfg_addr == 5'(3*k + 3)) rp_sh_d[k] = cfg_data;
      end
    end
  end

  // Active copies take the pre-write shadow, so a write on a load cycle waits
  // for the following load point.
  assign load    = (state_q == S_IDLE) || (cnt_q == per_a_q - CW'(1));
  assign per_a_d = load ? per_sh_q : per_a_q;
  assign st_a_d  = load ? st_sh_q  : st_a_q;
  assign wd_a_d  = load ? wd_sh_q  : wd_a_q;
  assign rp_a_d  = load ? rp_sh_q  : rp_a_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    sync_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run && per_a_d >= CW'(2)) begin
          state_d = S_RUN;
          sync_d  = 1'b1;
        end
      end
      default: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (load) begin
          if (per_a_d >= CW'(2)) sync_d = 1'b1;
          else                   state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    active_d = (state_d == S_RUN);
    pc_d     = !run ? 16'd0 : (sync_d ? pc_q + 16'd1 : pc_q);
  end

  assign go = (state_d == S_RUN);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    ptg_chan #(.CW(CW)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .go      (go),
      .first   (sync_d),
      .cnt     (cnt_d),
      .start   (st_a_d[k]),
      .width   (wd_a_d[k]),
      .rep     (rp_a_d[k]),
      .pulse_q (pulse_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sync_q   <= 1'b0;
      active_q <= 1'b0;
      pc_q     <= '0;
      per_sh_q <= '0;
      st_sh_q  <= '0;
      wd_sh_q  <= '0;
      rp_sh_q  <= '0;
      per_a_q  <= '0;
      st_a_q   <= '0;
      wd_a_q   <= '0;
      rp_a_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      active_q <= active_d;
      pc_q     <= pc_d;
      per_sh_q <= per_sh_d;
      st_sh_q  <= st_sh_d;
      wd_sh_q  <= wd_sh_d;
      rp_sh_q  <= rp_sh_d;
      per_a_q  <= per_a_d;
      st_a_q   <= st_a_d;
      wd_a_q   <= wd_a_d;
      rp_a_q   <= rp_a_d;
    end
  end

  assign sync_out  = sync_q;
  assign pulse_out = pulse_q;
  assign per_count = pc_q;
  assign active    = active_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed scenarios plus random traffic, all
// scored every cycle against a window-enumeration reference model.

module tb_pulse_train_gen;
  localparam int NCH = 4;
  localparam int CW  = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1, run = 1'b0, cfg_we = 1'b0;
  logic [4:0]     cfg_addr = '0;
  logic [CW-1:0]  cfg_data = '0;
  logic           sync_out, active;
  logic [NCH-1:0] pulse_out;
  logic [15:0]    per_count;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  pulse_train_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .sync_out(sync_out), .pulse_out(pulse_out),
    .per_count(per_count), .active(active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint s_per, a_per;
  longint s_st[NCH], s_wd[NCH], s_rp[NCH], a_st[NCH], a_wd[NCH], a_rp[NCH];
  bit     m_run, m_ld;
  longint m_cnt;
  logic [15:0]    exp_pc;
  logic           exp_sync, exp_act;
  logic [NCH-1:0] exp_pulse;

  function automatic bit win(longint st, longint wd, longint rp, longint n);
    longint r = rp & 255;
    longint s = rp >> 8;
    for (longint i = 0; i <= r; i++)
      if (n >= st + i*s && n < st + i*s + wd) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      s_per = 0; a_per = 0;
      for (int k = 0; k < NCH; k++) begin
        s_st[k] = 0; s_wd[k] = 0; s_rp[k] = 0; a_st[k] = 0; a_wd[k] = 0; a_rp[k] = 0;
      end
      m_run = 0; m_cnt = 0; exp_pc = 0;
    end else begin
      m_ld = !m_run || (m_cnt == a_per - 1);
      if (m_ld) begin
        a_per = s_per; a_st = s_st; a_wd = s_wd; a_rp = s_rp;
      end
      if (cfg_we) begin
        if (cfg_addr == 0) s_per = cfg_data;
        else if ((int'(cfg_addr) - 1) / 3 < NCH) begin
          case ((int'(cfg_addr) - 1) % 3)
            0: s_st[(int'(cfg_addr) - 1) / 3] = cfg_data;
            1: s_wd[(int'(cfg_addr) - 1) / 3] = cfg_data;
            default: s_rp[(int'(cfg_addr) - 1) / 3] = cfg_data;
          endcase
        end
      end
      if (!m_run) begin
        if (run && a_per >= 2) begin m_run = 1; m_cnt = 0; end
      end else if (!run) begin
        m_run = 0; m_cnt = 0;
      end else if (m_ld) begin
        m_cnt = 0;
        if (a_per < 2) m_run = 0;
      end else begin
        m_cnt++;
      end
      if (!run) exp_pc = 0;
      else if (m_run && m_cnt == 0) exp_pc++;
    end
    exp_sync = m_run && m_cnt == 0;
    exp_act  = m_run;
    for (int k = 0; k < NCH; k++)
      exp_pulse[k] = m_run && win(a_st[k], a_wd[k], a_rp[k], m_cnt);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sync_out",  64'(sync_out),  64'(exp_sync));
      chk("active",    64'(active),    64'(exp_act));
      chk("pulse_out", 64'(pulse_out), 64'(exp_pulse));
      chk("per_count", 64'(per_count), 64'(exp_pc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_sync();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sync_out === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL wait_sync: got no sync_out expected sync_out within 300 cycles");
  endtask

  // Called at the count-0 negedge; bit i holds channel ch at count i.
  task automatic capture(input int n, input int ch, output logic [63:0] v);
    v = '0;
    v[0] = pulse_out[ch];
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      v[i] = pulse_out[ch];
    end
  endtask

  task automatic count_ones(input int n, input int ch, output int c);
    logic [63:0] v;
    capture(n, ch, v);
    c = $countones(v);
  endtask

  function automatic logic [CW-1:0] rnd_data(input logic [4:0] a);
    if ($urandom_range(0, 19) == 0) return $urandom;
    if (a == 0) return CW'($urandom_range(0, 40));
    case ((int'(a) - 1) % 3)
      0: return CW'($urandom_range(0, 40));
      1: return CW'($urandom_range(0, 15));
      default: return CW'(($urandom_range(0, 10) << 8) | $urandom_range(0, 5));
    endcase
  endfunction

  logic [63:0] v;
  int          n, syncs;

  initial begin
    repeat (3) step();
    chk_en = 1;
    @(negedge clk);
    chk("rst_outs", {sync_out, active, pulse_out, per_count}, '0);
    reset = 1'b0;

    // basic pulse
    wr(0, 20); wr(1, 3); wr(2, 4); wr(3, 0);
    run = 1'b1;
    wait_sync();
    chk("basic_pc1", 64'(per_count), 1);
    capture(20, 0, v);
    chk("basic_mask", v, 64'h78);
    wait_sync();
    chk("basic_pc2", 64'(per_count), 2);
    chk("model_pc2", 64'(exp_pc), 2);

    // CPMG train on channel 1
    run = 1'b0; step();
    wr(0, 30); wr(4, 2); wr(5, 2); wr(6, (5 << 8) | 3);
    run = 1'b1;
    wait_sync();
    capture(30, 1, v);
    chk("cpmg_mask", v, 64'h6318C);

    // truncation, then overlapping repeats on channel 2
    run = 1'b0; step();
    wr(0, 10); wr(1, 8); wr(2, 5); wr(3, 0);
    wr(7, 1); wr(8, 3); wr(9, (1 << 8) | 2);
    run = 1'b1;
    wait_sync();
    capture(20, 0, v);
    chk("trunc_mask", v, 64'hC0300);
    wait_sync();
    capture(10, 2, v);
    chk("overlap_mask", v, 64'h3E);

    // double buffering
    run = 1'b0; step();
    wr(0, 20); wr(1, 3); wr(2, 4); wr(3, 0);
    run = 1'b1;
    wait_sync();
    repeat (5) step();
    wr(2, 10);
    @(negedge clk);
    @(negedge clk);
    chk("dbuf_cur_c7", 64'(pulse_out[0]), 0);
    chk("model_dbuf_c7", 64'(exp_pulse[0]), 0);
    wait_sync();
    count_ones(20, 0, n);
    chk("dbuf_next_w", 64'(n), 10);
    wait_sync();
    repeat (19) step();
    wr(2, 2);
    wait_sync();
    count_ones(20, 0, n);
    chk("dbuf_lp_w1", 64'(n), 10);
    wait_sync();
    count_ones(20, 0, n);
    chk("dbuf_lp_w2", 64'(n), 2);

    // idle cases
    run = 1'b0; step();
    wr(0, 1);
    run = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk("per1_idle", {sync_out, active, pulse_out}, '0);
    wr(0, 20);
    wait_sync();
    repeat (7) step();
    run = 1'b0;
    step();
    @(negedge clk);
    chk("rundrop_outs", {sync_out, active, pulse_out, per_count}, '0);
    run = 1'b1;
    step();
    @(negedge clk);
    chk("rerun_sync", {sync_out, active, per_count}, {1'b1, 1'b1, 16'd1});

    // reset mid-period with a pulse high
    wr(2, 4);
    wait_sync();
    wait_sync();
    repeat (4) step();
    @(negedge clk);
    chk("rst_pre_pulse", 64'(pulse_out[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {sync_out, active, pulse_out, per_count}, '0);
    syncs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sync_out === 1'b1) syncs++;
    end
    chk("rst_no_sync", 64'(syncs), 0);

    // random traffic
    run = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 3) run = ~run;
      cfg_we   = ($urandom_range(0, 99) < 20);
      cfg_addr = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 12)) : 5'($urandom_range(0, 31));
      cfg_data = rnd_data(cfg_addr);
      step();
    end
    reset = 1'b0; cfg_we = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of pulse channels, 1..8.
REQ-002 SHALL have parameter CW, default 32: width of the period counter and all timing registers.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: high enables period generation; low idles the block.
REQ-006 SHALL have port cfg_we, input, 1 bit: configuration write strobe, one write per cycle.
REQ-007 SHALL have port cfg_addr, input, 5 bits: configuration register address.
REQ-008 SHALL have port cfg_data, input, CW bits: configuration write data.
REQ-009 SHALL have port sync_out, output, 1 bit: one-cycle strobe at the start of each period.
REQ-010 SHALL have port pulse_out, output, NCH bits: per-channel pulse outputs.
REQ-011 SHALL have port per_count, output, 16 bits: number of periods started since reset or since run last rose; wraps at 16 bits.
REQ-012 SHALL have port active, output, 1 bit: high while periods are being generated.

Function
REQ-013 Register map SHALL be: addr 0 = PERIOD; addr 1+3k = START_k; addr 2+3k = WIDTH_k; addr 3+3k = REP_k, with REP bits[7:0] = repeat count R and bits[CW-1:8] = spacing S.
REQ-014 Writes to unmapped addresses, or to channels k >= NCH, SHALL be ignored.
REQ-015 Every register SHALL be double-buffered: a write updates a shadow copy; shadow SHALL be copied to active at load points only.
REQ-016 Load points SHALL be (a) every cycle while idle and (b) the last cycle of a period (count = PERIOD-1).
REQ-017 A write that lands on a load-point cycle SHALL take effect at the next load point, not the current one.
REQ-018 Internal count SHALL run 0..PERIOD-1 and then wrap to 0, using the active PERIOD.
REQ-019 Generation SHALL require run=1 and active PERIOD >= 2; otherwise the block SHALL be idle: count=0, outputs low, active=0.
REQ-020 First start: in the cycle after run is first sampled high with a valid PERIOD, active SHALL rise and sync_out SHALL pulse; that cycle is count 0.
REQ-021 sync_out SHALL be high exactly in count-0 cycles.
REQ-022 per_count SHALL increment on each sync_out and SHALL clear when run is low.
REQ-023 pulse_out[k] SHALL be high at count n iff, for some i in 0..R_k, START_k + i*S_k <= n < START_k + i*S_k + WIDTH_k.
REQ-024 Overlapping repeats SHALL OR together.
REQ-025 Arithmetic SHALL be CW+8 bits wide with no overflow wrap; pulse windows extending past PERIOD-1 SHALL be truncated at the period boundary and SHALL NOT spill into the next period.
REQ-026 WIDTH_k = 0 SHALL produce no pulse on channel k.
REQ-027 R_k = 0 SHALL produce a single pulse; S_k is then ignored.
REQ-028 All outputs SHALL be registered and glitch-free; the per-cycle channel evaluation SHALL be pipelined so its total latency is hidden, so that REQ-021 and REQ-023 hold exactly relative to the count.
REQ-029 Run falling mid-period SHALL force all outputs low in the next cycle and return count to 0; a new start then follows REQ-020.

Reset
REQ-030 On reset, all shadow and active registers SHALL clear to 0.
REQ-031 On reset, count SHALL clear to 0 and per_count SHALL clear to 0.
REQ-032 On reset, sync_out, pulse_out and active SHALL be driven 0 in the following cycle.
REQ-033 Reset SHALL take priority over run and cfg_we in the same cycle.
REQ-034 Reset mid-period SHALL abort the period with no partial pulse afterwards.

Verification
REQ-035 Basic pulse: PERIOD=20, START_0=3, WIDTH_0=4, R=0, run=1 -> sync_out at counts 0,20,40...; pulse_out[0] high at counts 3..6 of every period; per_count increments every 20 cycles.
REQ-036 Repeat (CPMG) train: START_1=2, WIDTH_1=2, R=3, S=5, PERIOD=30 -> pulse_out[1] high at counts 2-3, 7-8, 12-13, 17-18 only.
REQ-037 Truncation and overlap: PERIOD=10, START_0=8, WIDTH_0=5 -> high at counts 8-9 only, low at counts 0-2 of the next period; separately S=1, WIDTH=3, R=2 -> one continuous high run of 5 cycles.
REQ-038 Double buffering: write WIDTH_0=10 at count 5 -> current period unchanged, new width from the next period; a write landing at count PERIOD-1 -> effective one period later.
REQ-039 Idle cases: PERIOD=1 with run=1 -> active=0, all outputs low; run dropped at count 7 -> outputs low next cycle; run re-raised -> sync_out in the next cycle and per_count restarts at 1.
REQ-040 Reset mid-period at count 4 with pulse_out[0] high -> all outputs 0 next cycle and all registers 0; no sync_out until PERIOD is rewritten.
